// File: rtl/jk_seq_pkg.sv
// ---------------------------------------------------------------------------
// jk_seq_pkg
// Shared definitions for the J/K command sequencer:
//   - OP_* constants: command op encoding, which is literally the {j,k} drive
//   - jk_cmd_t      : packed {op, cnt} command at the default count width
//   - jk_next()     : next state of a JK flop given current q and {j,k}
// Ports: none (package).
// ---------------------------------------------------------------------------
package jk_seq_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    // Default repeat-count width; the sequencer's CW parameter defaults to it.
    localparam int JK_CW = 4;

    typedef struct packed {
        logic [1:0]       op;
        logic [JK_CW-1:0] cnt;
    } jk_cmd_t;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic q_n;
        case ({j, k})
            2'b00:   q_n = q;
            2'b01:   q_n = 1'b0;
            2'b10:   q_n = 1'b1;
            default: q_n = ~q;
        endcase
        return q_n;
    endfunction

endpackage

// File: rtl/jk_seq_fifo.sv
// ---------------------------------------------------------------------------
// jk_seq_fifo
// Synchronous FIFO holding queued sequencer commands. The pointers carry one
// extra wrap bit so that full and empty are distinguishable without a counter.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (flushes pointers)
//   push, wdata  : write request / data (ignored while full)
//   pop          : read request (ignored while empty)
//   rdata        : head entry, valid whenever !empty
//   full, empty  : occupancy flags, derived from registered pointers only
// ---------------------------------------------------------------------------
module jk_seq_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same slot, opposite lap: writer is exactly one lap ahead.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        // Storage needs no reset: entries are only read between push and pop.
        mem_q <= mem_d;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// jk_cmd_sequencer
// Queues {op, cnt} commands and plays each op onto registered j/k outputs for
// cnt+1 consecutive cycles, with no gap between back-to-back commands.
// Optional shadow model (build macro JK_SEQ_SHADOW_EN) tracks the expected
// jkff state and raises a sticky flag when the real flop disagrees.
//
// Handshake: a command is taken on any posedge with cmd_valid && cmd_ready;
// cmd_ready is !full of the registered FIFO state only, so it never depends on
// a pop in the same cycle, and cmd_valid may be held until accepted.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cmd_valid/op/cnt      : command offer; op = {j,k}, plays cnt+1 cycles
//   cmd_ready             : FIFO not full
//   j, k                  : registered drive to jkff
//   busy                  : high in every drive cycle of a command
//   done                  : high in the last drive cycle of each command
//   q_fb                  : jkff.q feedback         (JK_SEQ_SHADOW_EN only)
//   shadow_q              : expected jkff.q         (JK_SEQ_SHADOW_EN only)
//   mismatch              : sticky divergence flag  (JK_SEQ_SHADOW_EN only)
//   dbg_state             : FSM state (0 IDLE, 1 RUN) for observation
// ---------------------------------------------------------------------------
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = JK_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_cnt,
    output logic          cmd_ready,
    output logic          j,
    output logic          k,
    output logic          busy,
    output logic          done,
`ifdef JK_SEQ_SHADOW_EN
    input  logic          q_fb,
    output logic          shadow_q,
    output logic          mismatch,
`endif
    output logic [0:0]    dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [1:0]    op;
        logic [CW-1:0] cnt;
    } cmd_t;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] remain_q, remain_d;
    logic [1:0]    jk_q, jk_d;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic          load_next;
    cmd_t          fifo_wdata, fifo_head;

    assign fifo_wdata = '{op: cmd_op, cnt: cmd_cnt};
    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;

    jk_seq_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        jk_d      = jk_q;
        load_next = 1'b0;
        if (state_q == ST_IDLE) begin
            if (!fifo_empty) begin
                load_next = 1'b1;
            end else begin
                jk_d = OP_HOLD;
            end
        end else begin
            if (remain_q != '0) begin
                remain_d = remain_q - 1'b1;
            end else if (!fifo_empty) begin
                // Last cycle of this command: chain the next one with no gap.
                load_next = 1'b1;
            end else begin
                state_d = ST_IDLE;
                jk_d    = OP_HOLD;
            end
        end
        if (load_next) begin
            state_d  = ST_RUN;
            jk_d     = fifo_head.op;
            remain_d = fifo_head.cnt;
        end
    end

    assign fifo_pop  = load_next;
    assign busy      = (state_q == ST_RUN);
    assign done      = busy && (remain_q == '0);
    assign j         = jk_q[1];
    assign k         = jk_q[0];
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            jk_q     <= OP_HOLD;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            jk_q     <= jk_d;
        end
    end

`ifdef JK_SEQ_SHADOW_EN
    logic shadow_d, mismatch_d;

    // The shadow sees the same registered {j,k} the real flop samples, so
    // shadow_q and jkff.q advance on the same edge and are directly comparable.
    always_comb begin
        shadow_d   = jk_next(shadow_q, jk_q[1], jk_q[0]);
        mismatch_d = mismatch || (q_fb != shadow_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            mismatch <= mismatch_d;
        end
    end
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jk_cmd_sequencer
// Directed bench for jk_cmd_sequencer (DEPTH=4, CW=4). Inputs change and
// outputs are sampled 1 time unit after each posedge. A negedge monitor pops
// the expected {op, last} per drive cycle from exp_q. With JK_SEQ_SHADOW_EN
// defined, a behavioural jkff closes the q_fb loop.
// ---------------------------------------------------------------------------
module tb_jk_cmd_sequencer;
    import jk_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_cnt = 4'd0;
    logic       cmd_ready, j, k, busy, done;
    logic [0:0] dbg_state;
`ifdef JK_SEQ_SHADOW_EN
    logic       q_fb, shadow_q, mismatch;
    logic       jkff_q = 1'b0;
    logic       inv_fb = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q[$];

    jk_cmd_sequencer #(.DEPTH(4), .CW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_ready (cmd_ready),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
`ifdef JK_SEQ_SHADOW_EN
        .q_fb      (q_fb),
        .shadow_q  (shadow_q),
        .mismatch  (mismatch),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

`ifdef JK_SEQ_SHADOW_EN
    // Downstream flop, reset by the same reset as the sequencer.
    always @(posedge clk) begin
        if (reset) jkff_q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   jkff_q <= 1'b0;
                2'b10:   jkff_q <= 1'b1;
                2'b11:   jkff_q <= ~jkff_q;
                default: jkff_q <= jkff_q;
            endcase
        end
    end
    assign q_fb = jkff_q ^ inv_fb;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Offers one command, holding valid until accepted (bounded wait), and
    // records the cnt+1 drive cycles it must produce.
    task automatic push_cmd(input logic [1:0] op, input logic [3:0] cnt);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        while (!cmd_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!cmd_ready) begin
            check("push_timeout", 32'd0, 32'd1);
        end else begin
            tick();
            for (int i = 0; i <= int'(cnt); i++) exp_q.push_back({op, i == int'(cnt)});
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_busy", busy, 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [2:0] e;
        if (busy || j || k || done) begin
            if (exp_q.size() == 0) begin
                check("drive_unexpected", {busy, j, k, done}, 4'b0000);
            end else begin
                e = exp_q.pop_front();
                check("drive", {busy, j, k, done}, {1'b1, e});
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] tbl2 [7] = '{4'b1110, 4'b1110, 4'b1110, 4'b1111,
                             4'b1100, 4'b1101, 4'b0000};
    jk_cmd_t    tbl3 [6] = '{'{OP_TGL, 4'd15}, '{OP_SET, 4'd1}, '{OP_CLR, 4'd2},
                             '{OP_HOLD, 4'd0}, '{OP_TGL, 4'd1}, '{OP_SET, 4'd2}};

    initial begin
        // Reset state
        do_reset();
        check("rst_out", {busy, j, k, done}, 4'b0000);
        check("rst_ready", cmd_ready, 1);
        check("rst_state", dbg_state, 0);
`ifdef JK_SEQ_SHADOW_EN
        check("rst_shadow", shadow_q, 0);
        check("rst_mismatch", mismatch, 0);
`endif

        // 1: SET cnt=0 -> one cycle of 10 starting two edges after accept
        push_cmd(OP_SET, 4'd0);
        check("t1_wait", {busy, j, k, done}, 4'b0000);
        tick();
        check("t1_drive", {busy, j, k, done}, 4'b1101);
        check("t1_state", dbg_state, 1);
        tick();
        check("t1_after", {busy, j, k, done}, 4'b0000);
`ifdef JK_SEQ_SHADOW_EN
        check("t1_shadow", shadow_q, 1);
`endif

        // 2: TGL cnt=3 then SET cnt=1, contiguous
        push_cmd(OP_TGL, 4'd3);
        push_cmd(OP_SET, 4'd1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t2_cyc%0d", i), {busy, j, k, done}, tbl2[i]);
            tick();
        end
`ifdef JK_SEQ_SHADOW_EN
        check("t2_shadow", shadow_q, 1);
        check("t2_model", shadow_q, jkff_q);
`endif

        // 3: overfill a DEPTH=4 FIFO while a 16-cycle command plays
        for (int i = 0; i < 4; i++) push_cmd(tbl3[i].op, tbl3[i].cnt);
        check("t3_ready_3", cmd_ready, 1);
        push_cmd(tbl3[4].op, tbl3[4].cnt);
        check("t3_ready_full", cmd_ready, 0);
        push_cmd(tbl3[5].op, tbl3[5].cnt);
        wait_drain();
        check("t3_ready_end", cmd_ready, 1);

        // 4: reset in the 3rd cycle of CLR cnt=7, with a push offered too
        push_cmd(OP_CLR, 4'd7);
        tick();
        tick();
        tick();
        check("t4_cyc3", {busy, j, k, done}, 4'b1010);
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_SET;
        cmd_cnt   = 4'd4;
        tick();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        exp_q.delete();
        check("t4_out", {busy, j, k, done}, 4'b0000);
        check("t4_ready", cmd_ready, 1);
        tick();
        tick();
        check("t4_empty", {busy, j, k}, 3'b000);
        push_cmd(OP_TGL, 4'd2);
        wait_drain();
`ifdef JK_SEQ_SHADOW_EN
        check("t4_shadow", shadow_q, 1);

        // 5: shadow compare, then one cycle of inverted feedback
        push_cmd(OP_TGL, 4'd2);
        push_cmd(OP_CLR, 4'd0);
        push_cmd(OP_TGL, 4'd0);
        push_cmd(OP_HOLD, 4'd1);
        wait_drain();
        check("t5_model", shadow_q, jkff_q);
        check("t5_shadow", shadow_q, 1);
        check("t5_mm_pre", mismatch, 0);
        inv_fb = 1'b1;
        tick();
        inv_fb = 1'b0;
        check("t5_mm_rise", mismatch, 1);
        tick();
        tick();
        tick();
        check("t5_mm_sticky", mismatch, 1);
        do_reset();
        check("t5_mm_clear", mismatch, 0);
`endif

        // 6: idle for 10 cycles
        begin
            int dones = 0;
            for (int i = 0; i < 10; i++) begin
                check($sformatf("t6_idle%0d", i), {busy, j, k}, 3'b000);
                if (done) dones++;
                tick();
            end
            check("t6_done_cnt", dones, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_cmd_sequencer.md
# jk_cmd_sequencer

Command sequencer that drives the J/K inputs of a downstream `jkff`. It accepts queued operations (hold, clear, set, toggle), each with a repeat count, over a valid/ready handshake. It buffers them in a small FIFO and plays each one onto registered `j`/`k` outputs for the requested number of cycles. An optional shadow model tracks the expected flop output and flags divergence from the real `q`.

## Interface
- `DEPTH`, default 4: command FIFO depth; power of two, ≥2.
- `CW`, default 4: repeat-count width; a command plays for `cmd_cnt+1` cycles.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_op`  in  2  operation, encoded as {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
- `cmd_cnt`  in  CW  repeat count minus one.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `j`  out  1  registered J drive to `jkff`.
- `k`  out  1  registered K drive to `jkff`.
- `busy`  out  1  high while a command is being played.
- `done`  out  1  one-cycle pulse in the final drive cycle of each command.
- `q_fb`  in  1  `jkff.q` feedback. Present only with `JK_SEQ_SHADOW_EN`.
- `shadow_q`  out  1  expected flop state. Present only with `JK_SEQ_SHADOW_EN`.
- `mismatch`  out  1  sticky divergence flag. Present only with `JK_SEQ_SHADOW_EN`.

## Operation
- **Accept:** a command is accepted on a posedge where `cmd_valid && cmd_ready`, and is written to the FIFO tail.
- **No bypass:** `cmd_ready` depends only on FIFO fullness, never on a same-cycle pop.
- **FSM states:** IDLE and RUN.
  - IDLE: if the FIFO is non-empty, pop the head, load `op` and `remain=cmd_cnt`, drive `{j,k}=op`, and go to RUN. Otherwise `{j,k}=00`.
  - RUN: when `remain>0`, decrement it and hold `{j,k}`.
  - RUN, last cycle (`remain==0`): `done=1`. If the FIFO is non-empty, pop the next command and load it at this edge, so there is no gap cycle. Otherwise go to IDLE, with `{j,k}=00` from the next cycle.
- **busy:** high exactly during drive cycles of a command.
- **Widths:** `remain` is CW bits. The maximum count `2^CW-1` gives `2^CW` drive cycles. There is no wrap; `remain` is never decremented below 0.
- **Reset:** takes effect at the next posedge and overrides everything, including mid-command and push/pop in the same cycle.
  - Flushes the FIFO (pointers 0) and puts the FSM in IDLE.
  - Output values: `j=0`, `k=0`, `busy=0`, `done=0`, `cmd_ready=1`, `shadow_q=0`, `mismatch=0`.
  - The same reset clears `jkff`, so both sides restart at q=0.
- **Simultaneous push and pop** with the FIFO non-full: both occur and the count is unchanged.

## Timing
- **Latency:** a command accepted at edge N into an empty FIFO while IDLE is popped at edge N+1. Its `{j,k}` is visible after edge N+1 and is sampled by `jkff` at edge N+2.
- **Drive length:** each command drives for exactly `cmd_cnt+1` consecutive cycles.
- **Back-to-back commands** produce contiguous drive with no idle cycle.
- **`done`:** coincides with the last drive cycle, not the cycle after it.
- **`shadow_q`:** updates at each posedge from the current `{j,k}` using `jkff` semantics, so it equals `jkff.q` in the same cycle.
- **`mismatch`:** registered. It is set one cycle after the first cycle where `q_fb != shadow_q`, and clears only on reset.

## Configuration
- **Macro:** `JK_SEQ_SHADOW_EN`.
- **Defined:** the `q_fb`, `shadow_q` and `mismatch` ports exist, along with the shadow register and compare logic.
- **Undefined:** those ports and the associated logic are absent. Sequencing behaviour is identical either way.

## Structure
- **Package `jk_seq_pkg`:**
  - Op constants `OP_HOLD=2'b00`, `OP_CLR=2'b01`, `OP_SET=2'b10`, `OP_TGL=2'b11`.
  - Packed command struct {op, cnt}.
  - Function `jk_next(q, j, k)` returning the next flop state.
- **Sub-module `jk_seq_fifo`:** synchronous FIFO, parameterised width/depth. Ports push/pop/full/empty; it uses an extra pointer bit to tell full from empty.
- **Top level:** FSM, counter and optional shadow logic.

## Test plan
- Reset, then push SET with cnt=0. Required: `{j,k}=10` for 1 cycle, starting 2 cycles after accept; `done` pulses in that cycle; `shadow_q=1` afterwards.
- Push TGL cnt=3, then SET cnt=1, back-to-back. Required: 4 cycles of 11 immediately followed by 2 cycles of 10, with no gap; `done` pulses twice; `shadow_q` ends at 1.
- With DEPTH=4, push 6 commands while the first plays cnt=15. Required: `cmd_ready` drops after the FIFO holds 4 entries; no command is lost; commands play out in order.
- Assert `reset` during the 3rd cycle of a CLR cnt=7. Required: next cycle `j=k=0`, `busy=0`, FIFO empty, `cmd_ready=1`; a later push plays normally.
- With the macro defined and `jkff` connected: random ops, then force `q_fb` inverted for 1 cycle. Required: `mismatch` rises one cycle later and stays high until reset.
- With the FIFO empty and IDLE for 10 cycles: `{j,k}` stays 00, `busy=0`, no `done` pulse.
